// File: rtl/shift_register_n_if.sv
// Bundles the control, data and status signals of the multi-step shift register.
// Carries no logic, so it adds no latency.
// Carries no flow control; Busy and Done report progress to the master side.
interface shift_register_n_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) ();
   logic [WIDTH-1:0] DATA_IN;
   logic             ParallelLoadn;
   logic [2:0]       Mode;
   logic             Start;
   logic [AMT_W-1:0] Amount;
   logic             SerialIn;
   logic [WIDTH-1:0] Q_out;
   logic             SerialOut;
   logic             Busy;
   logic             Done;

   // Requester side: drives requests and observes the register.
   modport master (
      output DATA_IN, ParallelLoadn, Mode, Start, Amount, SerialIn,
      input  Q_out, SerialOut, Busy, Done
   );

   // Shift register side.
   modport slave (
      input  DATA_IN, ParallelLoadn, Mode, Start, Amount, SerialIn,
      output Q_out, SerialOut, Busy, Done
   );
endinterface

// File: rtl/shift_register_n.sv
// Shift/rotate register that performs N single-bit steps per Start request.
// Latency: a load takes 1 edge; a shift takes N edges after acceptance, and Done follows the last edge.
// Backpressure: requests are ignored while Busy; a held Start is taken again once the block is idle.
module shift_register_n #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   shift_register_n_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic             r_sout;
   logic             r_done;
   logic [AMT_W-1:0] r_cnt;
   logic [2:0]       r_mode;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_sout_nxt;
   logic             w_done_nxt;
   logic [AMT_W-1:0] w_cnt_nxt;
   logic [2:0]       w_mode_nxt;

   logic [WIDTH-1:0] w_step_q;
   logic             w_step_bit;
   logic             w_step_vld;

   // Result of one step in the latched mode; undefined modes leave Q and SerialOut alone.
   always_comb begin
      w_step_q   = r_q;
      w_step_bit = r_sout;
      w_step_vld = 1'b1;
      case (r_mode)
         3'b000: begin
            w_step_q   = {bus.SerialIn, r_q[WIDTH-1:1]};
            w_step_bit = r_q[0];
         end
         3'b001: begin
            w_step_q   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            w_step_bit = r_q[0];
         end
         3'b010: begin
            w_step_q   = {r_q[0], r_q[WIDTH-1:1]};
            w_step_bit = r_q[0];
         end
         3'b011: begin
            w_step_q   = {r_q[WIDTH-2:0], bus.SerialIn};
            w_step_bit = r_q[WIDTH-1];
         end
         3'b100: begin
            w_step_q   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_step_bit = r_q[WIDTH-1];
         end
         default: begin
            w_step_vld = 1'b0;
         end
      endcase
   end

   // Next-state and next-register decisions; requests are only looked at in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_sout_nxt  = r_sout;
      w_done_nxt  = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_mode_nxt  = r_mode;
      case (r_state)
         IDLE: begin
            if (!bus.ParallelLoadn) begin
               // Load wins over a simultaneous Start.
               w_q_nxt = bus.DATA_IN;
            end else if (bus.Start) begin
               if (bus.Amount == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_mode_nxt  = bus.Mode;
                  w_cnt_nxt   = bus.Amount;
                  w_state_nxt = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (w_step_vld) begin
               w_q_nxt    = w_step_q;
               w_sout_nxt = w_step_bit;
            end
            w_cnt_nxt = r_cnt - AMT_W'(1);
            if (r_cnt == AMT_W'(1)) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and status registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_q    <= '0;
         r_sout <= 1'b0;
         r_done <= 1'b0;
         r_cnt  <= '0;
         r_mode <= 3'b000;
      end else begin
         r_q    <= w_q_nxt;
         r_sout <= w_sout_nxt;
         r_done <= w_done_nxt;
         r_cnt  <= w_cnt_nxt;
         r_mode <= w_mode_nxt;
      end
   end

   assign bus.Q_out     = r_q;
   assign bus.SerialOut = r_sout;
   assign bus.Busy      = (r_state == SHIFT);
   assign bus.Done      = r_done;

endmodule

// File: doc/shift_register_n.md
SHIFT_REGISTER_N -- requirements
Module: shift_register_n

Interface
- REQ-001: Parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
- REQ-002: Parameter AMT_W, default 4, shift-amount width in bits; Amount range 0 .. 2^AMT_W-1.
- REQ-003: clock  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: DATA_IN  input  WIDTH  parallel load data.
- REQ-006: ParallelLoadn  input  1  active-low parallel load request.
- REQ-007: Mode  input  3  shift mode, sampled only when Start is accepted.
- REQ-008: Start  input  1  active-high request to begin a multi-step shift.
- REQ-009: Amount  input  AMT_W  number of single-bit steps, sampled with Start.
- REQ-010: SerialIn  input  1  fill bit for LSR/LSL, sampled every step.
- REQ-011: Q_out  output  WIDTH  register contents.
- REQ-012: SerialOut  output  1  registered copy of the bit shifted out by the most recent step.
- REQ-013: Busy  output  1  high while a shift operation is in progress.
- REQ-014: Done  output  1  single-cycle pulse marking operation completion.

Function
- REQ-015: The FSM SHALL have two states: IDLE and SHIFT; Busy = (state == SHIFT).
- REQ-016: In IDLE, when ParallelLoadn=0, Q_out SHALL load DATA_IN at the next edge; load takes priority over Start in the same cycle.
- REQ-017: In IDLE, when ParallelLoadn=1, Start=1 and Amount=N>0, the block SHALL latch Mode, load the step counter with N, and enter SHIFT at that edge (edge k), leaving Q_out unchanged.
- REQ-018: In IDLE, Start=1 with Amount=0 SHALL leave Q_out unchanged, stay in IDLE, and assert Done for the one cycle after the edge.
- REQ-019: In SHIFT, each edge SHALL perform exactly one step and decrement the counter; the step at edge k+N is the last, returning to IDLE with Done=1 for exactly one cycle after it.
- REQ-020: Busy SHALL be high for exactly N cycles (after edge k through edge k+N); Done and Busy SHALL never be high together.
- REQ-021: Mode 000 LSR: Q <= {SerialIn, Q[WIDTH-1:1]}, out bit Q[0].
- REQ-022: Mode 001 ASR: Q <= {Q[WIDTH-1], Q[WIDTH-1:1]}, out bit Q[0].
- REQ-023: Mode 010 ROR: Q <= {Q[0], Q[WIDTH-1:1]}, out bit Q[0].
- REQ-024: Mode 011 LSL: Q <= {Q[WIDTH-2:0], SerialIn}, out bit Q[WIDTH-1].
- REQ-025: Mode 100 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}, out bit Q[WIDTH-1].
- REQ-026: Modes 101-111 SHALL hold Q_out each step while still consuming N cycles, asserting Busy and then Done; SerialOut holds.
- REQ-027: SerialOut SHALL update to the out bit on every step and hold otherwise, including through loads.
- REQ-028: N >= WIDTH SHALL be legal: rotates wrap modulo WIDTH, and logical shifts fill entirely with SerialIn values.
- REQ-029: While Busy, ParallelLoadn, Start, Mode and Amount SHALL be ignored; a held Start is re-accepted on the first IDLE cycle after Done.

Reset
- REQ-030: reset=0 SHALL immediately and asynchronously force Q_out=0, SerialOut=0, Busy=0, Done=0, counter=0, and state=IDLE.
- REQ-031: Reset asserted mid-operation SHALL abort the operation with no Done pulse; after release, the block SHALL accept requests on the first edge.

Verification (WIDTH=8, AMT_W=4)
- REQ-032: Load 0xB5, then Start Mode=010 Amount=3 -> Q_out is 0xDA, 0x6D, 0xB6 over successive cycles; Busy high 3 cycles; Done 1 cycle; SerialOut=1.
- REQ-033: Load 0x90, then Mode=001 Amount=2 -> Q_out=0xE4, SerialOut=0.
- REQ-034: Load 0xFF, then Mode=000 SerialIn=0 Amount=9 -> Q_out=0x00 after 9 Busy cycles; Done single pulse.
- REQ-035: Load 0x0F, then Mode=011 SerialIn=1 Amount=4 -> Q_out=0xFF, SerialOut=0.
- REQ-036: Same cycle ParallelLoadn=0, Start=1, DATA_IN=0x3C -> Q_out=0x3C, Busy stays 0; Start while Busy -> ignored; Amount=0 -> Done next cycle, Q_out unchanged.
- REQ-037: reset=0 between clock edges during the 2nd step of a 5-step shift -> all outputs 0 immediately, no Done; after release, load 0xA5 -> Q_out=0xA5.
